// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Contents: FSM state encoding, input width, output digit count and the
// largest value that fits in the four output digits.
package bin2bcd_pkg;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int MAX_VAL = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle of the binary-to-BCD converter.
// Signals:
//   start_i  request a conversion of bin_i (sampled only while idle)
//   bin_i    unsigned binary input
//   busy_o   conversion in progress (SHIFT or DONE)
//   done_o   one-cycle pulse, bcd_o/ovf_o valid
//   bcd_o    four packed BCD digits, thousands in [15:12]
//   ovf_o    last conversion exceeded four digits (saturating build only)
// Modports: master = requester, slave = converter.
interface bin2bcd_if;
  import bin2bcd_pkg::*;

  logic                  start_i;
  logic [BIN_W-1:0]      bin_i;
  logic                  busy_o;
  logic                  done_o;
  logic [4*DIGITS-1:0]   bcd_o;
  logic                  ovf_o;

  modport master (
    output start_i, bin_i,
    input  busy_o, done_o, bcd_o, ovf_o
  );

  modport slave (
    input  start_i, bin_i,
    output busy_o, done_o, bcd_o, ovf_o
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
// Ports:
//   digit_i  4-bit digit before correction
//   digit_o  4-bit digit after correction
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// A request is accepted in IDLE, 14 SHIFT cycles follow, then one DONE
// cycle presents the result with done_o. Result registers hold between
// conversions.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   bin2bcd_if.slave request/result bundle
// Build option:
//   BIN2BCD_SAT_EN  defined: values above 9999 saturate to 16'h9999 with
//                   ovf_o=1; undefined: the fifth digit is dropped
//                   (result mod 10000) and ovf_o is tied low.
//
// state | meaning
// IDLE  | waiting for start_i; result registers hold last value
// SHIFT | 14 cycles of add-3 then shift of {digits, binary}
// DONE  | one cycle, done_o=1, result valid
module bin2bcd_seq
  import bin2bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  bin2bcd_if.slave    bus
);

  // Five digits so that 16383 converts exactly before truncation/saturation.
  localparam int REG_DIGITS = DIGITS + 1;
  localparam int DIG_W      = 4 * REG_DIGITS;
  localparam int SR_W       = DIG_W + BIN_W;
  localparam int CNT_W      = $clog2(BIN_W);
  localparam int OUT_W      = 4 * DIGITS;

  state_t              state, state_nxt;
  logic [SR_W-1:0]     sreg;
  logic [SR_W-1:0]     sreg_shift;
  logic [DIG_W-1:0]    digits_adj;
  logic [CNT_W-1:0]    cnt;
  logic [OUT_W-1:0]    bcd_q;
  logic                ovf_q;
  logic                load;
  logic                shift_en;
  logic                finish;

  for (genvar g = 0; g < REG_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (sreg[BIN_W + 4*g +: 4]),
      .digit_o (digits_adj[4*g +: 4])
    );
  end

  // Full-width shift keeps every bit of the concatenation in use.
  assign sreg_shift = {digits_adj, sreg[BIN_W-1:0]} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_W'(BIN_W - 1)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= {{DIG_W{1'b0}}, bus.bin_i};
      cnt  <= '0;
    end else if (shift_en) begin
      sreg <= sreg_shift;
      cnt  <= cnt + 1'b1;
    end
  end

`ifdef BIN2BCD_SAT_EN
  // Inputs are at most 16383, so a non-zero fifth digit means > 9999.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (finish) begin
      if (|sreg_shift[BIN_W + OUT_W +: 4]) begin
        bcd_q <= 16'h9999;
        ovf_q <= 1'b1;
      end else begin
        bcd_q <= sreg_shift[BIN_W +: OUT_W];
        ovf_q <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
    end else if (finish) begin
      bcd_q <= sreg_shift[BIN_W +: OUT_W];
    end
  end
  assign ovf_q = 1'b0;
`endif

  assign bus.busy_o = (state != IDLE);
  assign bus.done_o = (state == DONE);
  assign bus.bcd_o  = bcd_q;
  assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
// Honours BIN2BCD_SAT_EN for the over-range expectations.
module tb_bin2bcd_seq;
  import bin2bcd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;

  bin2bcd_if bus ();

  bin2bcd_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done_o === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Starts one conversion from an idle state and returns observations:
  // lat = cycle (counted from the sampling edge) in which done_o rose,
  // busy1 = busy_o in the first cycle after acceptance.
  task automatic run_conv(input logic [BIN_W-1:0] v, output int lat,
                          output logic busy1, output logic [15:0] bcd,
                          output logic ovf);
    int guard;
    guard = 0;
    while (bus.busy_o === 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    bus.start_i = 1'b1;
    bus.bin_i   = v;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    lat   = 1;
    busy1 = bus.busy_o;
    while (bus.done_o !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bcd = bus.bcd_o;
    ovf = bus.ovf_o;
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0;
    bus.bin_i   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_checks++; if (bus.done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done_o); else n_pass++;
    n_checks++; if (bus.bcd_o !== 16'h0000) $display("FAIL reset_bcd: got %h expected 0000", bus.bcd_o); else n_pass++;
    n_checks++; if (bus.ovf_o !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", bus.ovf_o); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; logic busy1; logic [15:0] bcd; logic ovf;
    run_conv(14'd1892, lat, busy1, bcd, ovf);
    n_checks++; if (busy1 !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy1); else n_pass++;
    n_checks++; if (lat != 15) $display("FAIL basic_latency: got %0d expected 15", lat); else n_pass++;
    n_checks++; if (bcd !== 16'h1892) $display("FAIL basic_bcd: got %h expected 1892", bcd); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL basic_ovf: got %b expected 0", ovf); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL basic_done_width: got done=%b busy=%b expected 0 0", bus.done_o, bus.busy_o); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.bcd_o !== 16'h1892) $display("FAIL basic_hold: got %h expected 1892", bus.bcd_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat; logic busy1; logic [15:0] bcd; logic ovf; int d0;
    d0 = done_cnt;
    run_conv(14'd1024, lat, busy1, bcd, ovf);
    n_checks++; if (bcd !== 16'h1024) $display("FAIL b2b_first: got %h expected 1024", bcd); else n_pass++;
    run_conv(14'd0, lat, busy1, bcd, ovf);
    n_checks++; if (bcd !== 16'h0000) $display("FAIL b2b_zero: got %h expected 0000", bcd); else n_pass++;
    n_checks++; if (lat != 15) $display("FAIL b2b_latency: got %0d expected 15", lat); else n_pass++;
    repeat (4) @(negedge clk);
    #1;
    n_checks++; if (done_cnt - d0 != 2) $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_boundary();
    int lat; logic busy1; logic [15:0] bcd; logic ovf;
    logic [15:0] exp_bcd; logic exp_ovf;
    run_conv(14'(MAX_VAL), lat, busy1, bcd, ovf);
    n_checks++; if (bcd !== 16'h9999) $display("FAIL max_bcd: got %h expected 9999", bcd); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL max_ovf: got %b expected 0", ovf); else n_pass++;
    run_conv(14'd9, lat, busy1, bcd, ovf);
    n_checks++; if (bcd !== 16'h0009) $display("FAIL nine_bcd: got %h expected 0009", bcd); else n_pass++;
`ifdef BIN2BCD_SAT_EN
    exp_bcd = 16'h9999; exp_ovf = 1'b1;
`else
    exp_bcd = 16'h2345; exp_ovf = 1'b0;
`endif
    run_conv(14'd12345, lat, busy1, bcd, ovf);
    n_checks++; if (bcd !== exp_bcd) $display("FAIL big_bcd: got %h expected %h", bcd, exp_bcd); else n_pass++;
    n_checks++; if (ovf !== exp_ovf) $display("FAIL big_ovf: got %b expected %b", ovf, exp_ovf); else n_pass++;
`ifndef BIN2BCD_SAT_EN
    exp_bcd = 16'h0000;
`endif
    run_conv(14'd10000, lat, busy1, bcd, ovf);
    n_checks++; if (bcd !== exp_bcd || ovf !== exp_ovf)
      $display("FAIL ten_k: got %h/%b expected %h/%b", bcd, ovf, exp_bcd, exp_ovf); else n_pass++;
`ifndef BIN2BCD_SAT_EN
    exp_bcd = 16'h6383;
`endif
    run_conv(14'((1 << BIN_W) - 1), lat, busy1, bcd, ovf);
    n_checks++; if (bcd !== exp_bcd || ovf !== exp_ovf)
      $display("FAIL full_scale: got %h/%b expected %h/%b", bcd, ovf, exp_bcd, exp_ovf); else n_pass++;
    n_checks++; if (lat != 15) $display("FAIL full_scale_latency: got %0d expected 15", lat); else n_pass++;
  endtask

  // start_i held high; bin_i is disturbed while busy and restored in DONE.
  task automatic test_continuous();
    int t; int nd; int done_t[3]; logic [15:0] done_bcd[3];
    int guard;
    guard = 0;
    while (bus.busy_o === 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    bus.start_i = 1'b1;
    bus.bin_i   = 14'd42;
    t = 0; nd = 0;
    while (nd < 3 && t < 80) begin
      @(negedge clk);
      t++;
      if (bus.done_o === 1'b1) begin
        done_t[nd]   = t;
        done_bcd[nd] = bus.bcd_o;
        nd++;
        bus.bin_i = 14'd42;
      end else if (bus.busy_o === 1'b1) begin
        bus.bin_i = 14'd7777;
      end
    end
    bus.start_i = 1'b0;
    bus.bin_i   = 14'd0;
    n_checks++; if (nd != 3) $display("FAIL cont_count: got %0d expected 3", nd); else n_pass++;
    if (nd == 3) begin
      n_checks++; if (done_t[0] != 15) $display("FAIL cont_first: got %0d expected 15", done_t[0]); else n_pass++;
      n_checks++; if (done_t[1] - done_t[0] != 16 || done_t[2] - done_t[1] != 16)
        $display("FAIL cont_period: got %0d,%0d expected 16,16", done_t[1] - done_t[0], done_t[2] - done_t[1]); else n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (done_bcd[i] !== 16'h0042) $display("FAIL cont_bcd%0d: got %h expected 0042", i, done_bcd[i]); else n_pass++;
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat; logic busy1; logic [15:0] bcd; logic ovf; int d0;
    n_checks++; if (bus.bcd_o !== 16'h0042) $display("FAIL rmid_pre: got %h expected 0042", bus.bcd_o); else n_pass++;
    bus.start_i = 1'b1;
    bus.bin_i   = 14'd5678;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0)
      $display("FAIL rmid_ctrl: got busy=%b done=%b expected 0 0", bus.busy_o, bus.done_o); else n_pass++;
    n_checks++; if (bus.bcd_o !== 16'h0000 || bus.ovf_o !== 1'b0)
      $display("FAIL rmid_data: got %h/%b expected 0000/0", bus.bcd_o, bus.ovf_o); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    #1;
    n_checks++; if (done_cnt != d0) $display("FAIL rmid_no_done: got %0d expected 0", done_cnt - d0); else n_pass++;
    run_conv(14'd5678, lat, busy1, bcd, ovf);
    n_checks++; if (bcd !== 16'h5678 || lat != 15)
      $display("FAIL rmid_restart: got %h lat %0d expected 5678 lat 15", bcd, lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundary();
    test_continuous();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start_i, input, 1 bit: request a conversion of bin_i; sampled only in IDLE.
REQ-005 Port bin_i, input, 14 bits: unsigned binary value, 0..16383.
REQ-006 Port busy_o, output, 1 bit: high while in SHIFT or DONE.
REQ-007 Port done_o, output, 1 bit: one-cycle pulse; bcd_o is valid in that cycle.
REQ-008 Port bcd_o, output, 16 bits: four packed BCD digits, [15:12] thousands down to [3:0] units; this is the direct feed to the downstream 4-digit multiplexed display's bcd_in.
REQ-009 Port ovf_o, output, 1 bit: the last completed conversion had bin_i > 9999; updated with bcd_o.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-011 IDLE with start_i=1: the block SHALL latch bin_i into the shift register, clear the digit register and iteration counter, and enter SHIFT on the same edge.
REQ-012 SHIFT: each cycle SHALL apply add-3 to every digit >=5, then shift {digits, binary} left by one.
REQ-013 SHIFT SHALL run exactly 14 cycles; on the 14th edge the FSM SHALL enter DONE and register bcd_o and ovf_o.
REQ-014 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-015 Latency: done_o SHALL be high in the 15th cycle after the edge that sampled start_i.
REQ-016 start_i SHALL be ignored while busy_o=1; a start_i held high in the DONE cycle SHALL NOT be accepted until IDLE.
REQ-017 bcd_o and ovf_o SHALL hold their value between conversions and change only on the edge entering DONE.
REQ-018 The internal digit register SHALL be 5 digits wide so that inputs up to 16383 convert without error; bcd_o SHALL carry only the low 4 digits.
REQ-019 Every digit of bcd_o SHALL be 0..9 for all inputs.

Reset
REQ-020 When rst=1 at any time, including mid-SHIFT, the block SHALL immediately enter IDLE with busy_o=0, done_o=0, bcd_o=16'h0000 and ovf_o=0, and clear the counter and shift register.
REQ-021 A conversion interrupted by reset SHALL be discarded; no done_o pulse SHALL follow it.

Configuration
REQ-022 Macro BIN2BCD_SAT_EN defined: inputs > 9999 SHALL produce bcd_o=16'h9999 and ovf_o=1; inputs <= 9999 SHALL produce ovf_o=0.
REQ-023 Macro BIN2BCD_SAT_EN undefined: bcd_o SHALL be the input value mod 10000 (the 5th digit is dropped), and ovf_o SHALL be constant 0.
REQ-024 Latency and handshake SHALL be identical with and without the macro.

Structure
REQ-025 Package bin2bcd_pkg SHALL hold the state typedef (IDLE/SHIFT/DONE) and the constants BIN_W=14, DIGITS=4 and MAX_VAL=9999.
REQ-026 Per-digit correction SHALL be a combinational sub-module bcd_add3: 4-bit in, 4-bit out, output = in+3 when in>=5, else in.
REQ-027 bin2bcd_seq SHALL instantiate bcd_add3 once per digit of the 5-digit register.

Verification
REQ-028 bin_i=1892, single start pulse -> done_o high 15 cycles later, bcd_o=16'h1892, ovf_o=0.
REQ-029 Back-to-back: bin_i=1024, then bin_i=0 after done -> bcd_o=16'h1024, then 16'h0000; exactly one done_o per start.
REQ-030 bin_i=9999 -> bcd_o=16'h9999, ovf_o=0; bin_i=12345 -> 16'h9999 with ovf_o=1 if BIN2BCD_SAT_EN, else 16'h2345 with ovf_o=0.
REQ-031 start_i held high continuously with bin_i=42 -> conversions every 16 cycles, and bin_i changes during SHIFT do not alter the result (16'h0042).
REQ-032 rst pulsed at SHIFT cycle 7 of bin_i=5678 -> all outputs zero asynchronously, no done_o; a new start then yields 16'h5678.
